// File: rtl/romulator_diagnostics_if.sv
// SPI link and RAM port of the ROMulator diagnostics block.
// master: host/system side (drives SPI, returns RAM read data).
// slave:  diagnostics block (answers SPI, drives the RAM port).
interface romulator_diagnostics_if;
  logic        diag_spi_cs;
  logic        spi_clk_in;
  logic        spi_miso;
  logic        diag_spi_out;
  logic [15:0] diag_ram_address;
  logic [7:0]  diag_ram_datain;
  logic        diag_ram_cs;
  logic        diag_ram_we;
  logic [7:0]  ram_dataout;

  modport master (
    output diag_spi_cs, spi_clk_in, spi_miso, ram_dataout,
    input  diag_spi_out, diag_ram_address, diag_ram_datain, diag_ram_cs, diag_ram_we
  );

  modport slave (
    input  diag_spi_cs, spi_clk_in, spi_miso, ram_dataout,
    output diag_spi_out, diag_ram_address, diag_ram_datain, diag_ram_cs, diag_ram_we
  );
endinterface

// File: rtl/romulator_diagnostics.sv
// ROMulator diagnostics: SPI mode-0 slave (MSB first, 8-bit frames) that can
// halt the CPU, stream RAM reads/writes, report status, set the VRAM window
// index and echo bytes. Replies to byte N are shifted out during byte N+1.
// Optional macro DIAG_VRAM_READ_EN enables the READ_VRAM (0x05) command;
// without it 0x05 is an unknown command and the VRAM read port is tied low.
module romulator_diagnostics (
  input  logic                   clk,
  input  logic                   reset,
  romulator_diagnostics_if.slave bus,
  input  logic [3:0]             configuration,
  input  logic [3:0]             out_flash_addr,
  input  logic [7:0]             vram_output,
  output logic                   halt,
  output logic [10:0]            vram_read_address,
  output logic                   vram_read_clock,
  output logic [3:0]             config_byte
);
  typedef enum logic [2:0] {
    ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_STREAM, ST_SETCFG, ST_ECHO, ST_IGNORE
  } state_t;
  typedef enum logic [1:0] {M_RD_RAM, M_WR_RAM, M_RD_VRAM} mode_t;

  logic [1:0]  cs_sync_q, sck_sync_q, mosi_sync_q;
  logic        sck_prev_q;
  logic        armed_q;
  state_t      state_q;
  mode_t       mode_q;
  logic [2:0]  bit_cnt_q;
  logic [6:0]  shreg_q;
  logic [7:0]  tx_q, reply_q, addr_hi_q;
  logic        spi_out_q, halt_q;
  logic [3:0]  cfg_q;
  logic [15:0] ram_addr_q;
  logic [7:0]  ram_din_q;
  logic        ram_cs_q, ram_we_q;
  logic        rd_req_q, rd_lat_q, vsel_q, wr_first_q;
`ifdef DIAG_VRAM_READ_EN
  logic [10:0] vram_addr_q;
`endif

  logic       cs_n, sck_rise, sck_fall, active, byte_done;
  logic [7:0] rx_byte;

  assign cs_n      = cs_sync_q[1];
  assign sck_rise  = sck_sync_q[1] & ~sck_prev_q;
  assign sck_fall  = ~sck_sync_q[1] & sck_prev_q;
  // A transaction only counts once CS has been seen high since reset.
  assign active    = armed_q & ~cs_n;
  assign byte_done = active & sck_rise & (bit_cnt_q == 3'd7);
  assign rx_byte   = {shreg_q, mosi_sync_q[1]};

  assign bus.diag_spi_out     = spi_out_q;
  assign bus.diag_ram_address = ram_addr_q;
  assign bus.diag_ram_datain  = ram_din_q;
  assign bus.diag_ram_cs      = ram_cs_q;
  assign bus.diag_ram_we      = ram_we_q;
  assign halt                 = halt_q;
  assign config_byte          = cfg_q;
`ifdef DIAG_VRAM_READ_EN
  assign vram_read_address    = vram_addr_q;
  assign vram_read_clock      = clk;
`else
  assign vram_read_address    = '0;
  assign vram_read_clock      = 1'b0;
`endif

  // Two-flop synchronizers for the SPI pins plus SCK edge history; CS resets
  // low so a transaction already in progress at reset is not picked up.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_sync_q   <= '0;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[0], bus.diag_spi_cs};
      sck_sync_q  <= {sck_sync_q[0], bus.spi_clk_in};
      mosi_sync_q <= {mosi_sync_q[0], bus.spi_miso};
      sck_prev_q  <= sck_sync_q[1];
    end
  end

  // Protocol FSM: bit shifting, command decode, RAM/VRAM access and replies.
  always_ff @(posedge clk) begin
    if (!reset) begin
      armed_q    <= 1'b0;
      state_q    <= ST_CMD;
      mode_q     <= M_RD_RAM;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= '0;
      reply_q    <= '0;
      addr_hi_q  <= '0;
      spi_out_q  <= 1'b0;
      halt_q     <= 1'b0;
      cfg_q      <= '0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      ram_cs_q   <= 1'b0;
      ram_we_q   <= 1'b0;
      rd_req_q   <= 1'b0;
      rd_lat_q   <= 1'b0;
      vsel_q     <= 1'b0;
      wr_first_q <= 1'b0;
`ifdef DIAG_VRAM_READ_EN
      vram_addr_q <= '0;
`endif
    end else begin
      // Access strobes are single-cycle; read data is captured two clocks
      // after the request (one for the address/cs, one for the memory).
      ram_cs_q <= 1'b0;
      ram_we_q <= 1'b0;
      rd_req_q <= 1'b0;
      rd_lat_q <= rd_req_q;
      if (rd_lat_q) reply_q <= vsel_q ? vram_output : bus.ram_dataout;
      if (cs_n) armed_q <= 1'b1;

      if (!active) begin
        state_q   <= ST_CMD;
        bit_cnt_q <= '0;
        tx_q      <= '0;
        reply_q   <= '0;
        spi_out_q <= 1'b0;
      end else begin
        if (sck_rise) begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          shreg_q   <= {shreg_q[5:0], mosi_sync_q[1]};
        end
        // First falling edge of a frame presents the pending reply's MSB.
        if (sck_fall) begin
          if (bit_cnt_q == 3'd0) begin
            spi_out_q <= reply_q[7];
            tx_q      <= {reply_q[6:0], 1'b0};
          end else begin
            spi_out_q <= tx_q[7];
            tx_q      <= {tx_q[6:0], 1'b0};
          end
        end
        if (byte_done) begin
          reply_q <= 8'h00;
          case (state_q)
            ST_CMD: begin
              state_q <= ST_IGNORE;
              case (rx_byte)
                8'h01: halt_q <= 1'b1;
                8'h02: halt_q <= 1'b0;
                8'h03: begin mode_q <= M_RD_RAM; state_q <= ST_ADDR_H; end
                8'h04: begin mode_q <= M_WR_RAM; state_q <= ST_ADDR_H; end
`ifdef DIAG_VRAM_READ_EN
                8'h05: begin mode_q <= M_RD_VRAM; state_q <= ST_ADDR_H; end
`endif
                8'h06: reply_q <= {out_flash_addr, configuration};
                8'h07: state_q <= ST_SETCFG;
                8'h08: state_q <= ST_ECHO;
                default: ;
              endcase
            end
            ST_ADDR_H: begin
              addr_hi_q <= rx_byte;
              state_q   <= ST_ADDR_L;
            end
            ST_ADDR_L: begin
              state_q    <= ST_STREAM;
              wr_first_q <= 1'b1;
              case (mode_q)
                M_RD_RAM: if (halt_q) begin
                  ram_addr_q <= {addr_hi_q, rx_byte};
                  ram_cs_q   <= 1'b1;
                  rd_req_q   <= 1'b1;
                  vsel_q     <= 1'b0;
                end
                M_WR_RAM: if (halt_q) ram_addr_q <= {addr_hi_q, rx_byte};
`ifdef DIAG_VRAM_READ_EN
                M_RD_VRAM: begin
                  vram_addr_q <= {addr_hi_q[2:0], rx_byte};
                  rd_req_q    <= 1'b1;
                  vsel_q      <= 1'b1;
                end
`endif
                default: ;
              endcase
            end
            ST_STREAM: begin
              case (mode_q)
                M_RD_RAM: if (halt_q) begin
                  ram_addr_q <= ram_addr_q + 16'd1;
                  ram_cs_q   <= 1'b1;
                  rd_req_q   <= 1'b1;
                  vsel_q     <= 1'b0;
                end
                // The first data byte goes to the loaded address, later ones
                // advance the pointer in the same cycle as the strobe.
                M_WR_RAM: if (halt_q) begin
                  ram_din_q  <= rx_byte;
                  ram_cs_q   <= 1'b1;
                  ram_we_q   <= 1'b1;
                  wr_first_q <= 1'b0;
                  if (!wr_first_q) ram_addr_q <= ram_addr_q + 16'd1;
                end
`ifdef DIAG_VRAM_READ_EN
                M_RD_VRAM: begin
                  vram_addr_q <= vram_addr_q + 11'd1;
                  rd_req_q    <= 1'b1;
                  vsel_q      <= 1'b1;
                end
`endif
                default: ;
              endcase
            end
            ST_SETCFG: begin
              cfg_q   <= rx_byte[3:0];
              state_q <= ST_IGNORE;
            end
            ST_ECHO: reply_q <= rx_byte;
            default: ;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_romulator_diagnostics.sv
// Scoreboard bench for romulator_diagnostics: stimulus pushes expected SPI
// replies and RAM accesses into queues; monitors pop and compare.
module tb_romulator_diagnostics;
  localparam int HALF = 8;

  typedef struct packed { logic [7:0] v; logic care; } spi_exp_t;
  typedef struct packed { logic we; logic [15:0] a; logic [7:0] d; } ram_exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  configuration, out_flash_addr, config_byte;
  logic [7:0]  vram_output;
  logic        halt, vram_read_clock;
  logic [10:0] vram_read_address;

  romulator_diagnostics_if bus();

  romulator_diagnostics dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus),
    .configuration     (configuration),
    .out_flash_addr    (out_flash_addr),
    .vram_output       (vram_output),
    .halt              (halt),
    .vram_read_address (vram_read_address),
    .vram_read_clock   (vram_read_clock),
    .config_byte       (config_byte)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  spi_exp_t spi_exp[$];
  ram_exp_t ram_exp[$];

  // RAM model: registered read one clock after cs.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (bus.diag_ram_cs) begin
      if (bus.diag_ram_we) mem[bus.diag_ram_address] <= bus.diag_ram_datain;
      else bus.ram_dataout <= mem[bus.diag_ram_address];
    end
  end

  // VRAM model: contents are a fixed function of the address.
  function automatic logic [7:0] vram_f(input logic [10:0] a);
    return {a[10:8], 5'b0} ^ a[7:0] ^ 8'h5A;
  endfunction
  always @(posedge clk) vram_output <= vram_f(vram_read_address);

  // SPI reply monitor: assembles each full frame seen by the host.
  logic [7:0] mon_sh;
  int         mon_bits = 0;
  int         mon_frame = 0;
  spi_exp_t   se;
  always @(posedge bus.spi_clk_in or posedge bus.diag_spi_cs or negedge reset) begin
    if (bus.diag_spi_cs || !reset) begin
      mon_bits = 0;
    end else begin
      mon_sh = {mon_sh[6:0], bus.diag_spi_out};
      mon_bits++;
      if (mon_bits == 8) begin
        mon_bits = 0;
        mon_frame++;
        if (spi_exp.size() == 0) begin
          checks++; errors++;
          $display("FAIL spi_extra_frame #%0d: got %02h, required no frame", mon_frame, mon_sh);
        end else begin
          se = spi_exp.pop_front();
          if (se.care) begin
            checks++;
            if (mon_sh !== se.v) begin
              errors++;
              $display("FAIL spi_reply #%0d: got %02h, required %02h", mon_frame, mon_sh, se.v);
            end
          end
        end
      end
    end
  end

  // RAM port monitor: every strobe must match the next expected access.
  ram_exp_t   re;
  logic [7:0] dchk;
  always @(negedge clk) begin
    if (reset) begin
      if (bus.diag_ram_we && !bus.diag_ram_cs) begin
        checks++; errors++;
        $display("FAIL ram_we_without_cs: we=1 cs=0, required we=0");
      end
      if (bus.diag_ram_cs) begin
        dchk = bus.diag_ram_we ? bus.diag_ram_datain : 8'h00;
        checks++;
        if (ram_exp.size() == 0) begin
          errors++;
          $display("FAIL ram_unexpected_access: we=%0b addr=%04h, required no access",
                   bus.diag_ram_we, bus.diag_ram_address);
        end else begin
          re = ram_exp.pop_front();
          if ({bus.diag_ram_we, bus.diag_ram_address, dchk} !== {re.we, re.a, re.d}) begin
            errors++;
            $display("FAIL ram_access: got we=%0b addr=%04h data=%02h, required we=%0b addr=%04h data=%02h",
                     bus.diag_ram_we, bus.diag_ram_address, dchk, re.we, re.a, re.d);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic send_bits(input logic [7:0] b, input int nbits);
    for (int i = 7; i > 7 - nbits; i--) begin
      bus.spi_miso = b[i];
      tick(HALF);
      bus.spi_clk_in = 1'b1;
      tick(HALF);
      bus.spi_clk_in = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] b, input logic [7:0] exp, input logic care);
    spi_exp.push_back({exp, care});
    send_bits(b, 8);
  endtask

  task automatic cs_low();
    bus.diag_spi_cs = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF);
    bus.diag_spi_cs = 1'b1;
    tick(2 * HALF);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.diag_spi_cs = 1'b1;
    bus.spi_clk_in  = 1'b0;
    bus.spi_miso    = 1'b0;
    configuration   = 4'h5;
    out_flash_addr  = 4'hA;
    reset           = 1'b0;
    tick(4);
    chk("reset_halt", 32'(halt), 32'h0);
    chk("reset_config_byte", 32'(config_byte), 32'h0);
    chk("reset_ram_ctl", 32'({bus.diag_ram_cs, bus.diag_ram_we}), 32'h0);
    chk("reset_ram_addr", 32'(bus.diag_ram_address), 32'h0);
    chk("reset_ram_datain", 32'(bus.diag_ram_datain), 32'h0);
    chk("reset_vram_addr", 32'(vram_read_address), 32'h0);
    chk("reset_spi_out", 32'(bus.diag_spi_out), 32'h0);
    reset = 1'b1;
    tick(4);

    // vram_read_clock follows clk only when VRAM reads are built in.
    @(posedge clk); #1;
`ifdef DIAG_VRAM_READ_EN
    chk("vram_clock_high", 32'(vram_read_clock), 32'h1);
`else
    chk("vram_clock_tied", 32'(vram_read_clock), 32'h0);
`endif
    tick(1);

    // HALT then RUN; no RAM strobes expected.
    cs_low(); frame(8'h01, 8'h00, 1'b1); cs_high();
    chk("halt_set", 32'(halt), 32'h1);
    cs_low(); frame(8'h02, 8'h00, 1'b1); cs_high();
    chk("halt_clear", 32'(halt), 32'h0);

    // Halted: write two bytes at 0x1234.
    cs_low(); frame(8'h01, 8'h00, 1'b1); cs_high();
    ram_exp.push_back({1'b1, 16'h1234, 8'hAA});
    ram_exp.push_back({1'b1, 16'h1235, 8'h55});
    cs_low();
    frame(8'h04, 8'h00, 1'b1); frame(8'h12, 8'h00, 1'b1); frame(8'h34, 8'h00, 1'b1);
    frame(8'hAA, 8'h00, 1'b1); frame(8'h55, 8'h00, 1'b1);
    cs_high();

    // Read them back; every byte after addrL triggers another read.
    for (int i = 0; i < 4; i++) ram_exp.push_back({1'b0, 16'h1234 + 16'(i), 8'h00});
    cs_low();
    frame(8'h03, 8'h00, 1'b1); frame(8'h12, 8'h00, 1'b1); frame(8'h34, 8'h00, 1'b1);
    frame(8'h00, 8'hAA, 1'b1); frame(8'h00, 8'h55, 1'b1); frame(8'h00, 8'h00, 1'b0);
    cs_high();

    // Address wrap at 0xFFFF for write and read.
    ram_exp.push_back({1'b1, 16'hFFFF, 8'hC3});
    ram_exp.push_back({1'b1, 16'h0000, 8'h3C});
    cs_low();
    frame(8'h04, 8'h00, 1'b1); frame(8'hFF, 8'h00, 1'b1); frame(8'hFF, 8'h00, 1'b1);
    frame(8'hC3, 8'h00, 1'b1); frame(8'h3C, 8'h00, 1'b1);
    cs_high();
    ram_exp.push_back({1'b0, 16'hFFFF, 8'h00});
    ram_exp.push_back({1'b0, 16'h0000, 8'h00});
    ram_exp.push_back({1'b0, 16'h0001, 8'h00});
    cs_low();
    frame(8'h03, 8'h00, 1'b1); frame(8'hFF, 8'h00, 1'b1); frame(8'hFF, 8'h00, 1'b1);
    frame(8'h00, 8'hC3, 1'b1); frame(8'h00, 8'h3C, 1'b1);
    cs_high();

    // STATUS and SET_CFG.
    cs_low(); frame(8'h06, 8'h00, 1'b1); frame(8'h00, 8'hA5, 1'b1); cs_high();
    cs_low(); frame(8'h07, 8'h00, 1'b1); frame(8'h03, 8'h00, 1'b1); cs_high();
    chk("config_byte_set", 32'(config_byte), 32'h3);

    // Not halted: RAM commands produce no strobes and zero replies.
    cs_low(); frame(8'h02, 8'h00, 1'b1); cs_high();
    chk("halt_clear_2", 32'(halt), 32'h0);
    cs_low();
    frame(8'h04, 8'h00, 1'b1); frame(8'h00, 8'h00, 1'b1); frame(8'h10, 8'h00, 1'b1);
    frame(8'h77, 8'h00, 1'b1);
    cs_high();
    cs_low();
    frame(8'h03, 8'h00, 1'b1); frame(8'h00, 8'h00, 1'b1); frame(8'h10, 8'h00, 1'b1);
    frame(8'h00, 8'h00, 1'b1);
    cs_high();

    // READ_VRAM at 0x7FF, wrapping to 0x000 (unknown command when not built in).
    cs_low();
    frame(8'h05, 8'h00, 1'b1); frame(8'h07, 8'h00, 1'b1); frame(8'hFF, 8'h00, 1'b1);
`ifdef DIAG_VRAM_READ_EN
    frame(8'h00, 8'h45, 1'b1); frame(8'h00, 8'h5A, 1'b1);
    cs_high();
    chk("vram_addr_after_stream", 32'(vram_read_address), 32'h001);
`else
    frame(8'h00, 8'h00, 1'b1); frame(8'h00, 8'h00, 1'b1);
    cs_high();
    chk("vram_addr_tied", 32'(vram_read_address), 32'h000);
`endif

    // CS raised after 4 bits of HALT: partial byte discarded.
    cs_low(); send_bits(8'h01, 4); cs_high();
    chk("partial_frame_halt", 32'(halt), 32'h0);
    cs_low();
    frame(8'h08, 8'h00, 1'b0); frame(8'h3C, 8'h00, 1'b1); frame(8'h00, 8'h3C, 1'b1);
    cs_high();

    // Reset mid-transaction: the rest of that transaction is ignored.
    cs_low(); send_bits(8'hC0, 2);
    reset = 1'b0; tick(3); reset = 1'b1; tick(2);
    frame(8'h01, 8'h00, 1'b1);
    cs_high();
    chk("reset_abort_halt", 32'(halt), 32'h0);
    chk("reset_abort_cfg", 32'(config_byte), 32'h0);
    cs_low(); frame(8'h01, 8'h00, 1'b1); cs_high();
    chk("halt_after_rearm", 32'(halt), 32'h1);

    tick(20);
    chk("spi_queue_drained", 32'(spi_exp.size()), 32'h0);
    chk("ram_queue_drained", 32'(ram_exp.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/romulator_diagnostics.md
ROMULATOR_DIAGNOSTICS -- requirements
Module: romulator_diagnostics

Interface
REQ-001 SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-002 clk  in  1  system clock (internal HF oscillator); all logic on rising edge.
REQ-003 reset  in  1  synchronous active-low reset.
REQ-004 diag_spi_cs  in  1  host SPI chip select, active-low; spi_clk_in  in  1  host SPI clock; spi_miso  in  1  host-to-block serial data.
REQ-005 diag_spi_out  out  1  block-to-host serial data.
REQ-006 halt  out  1  CPU halt request; while 1, this block owns the RAM port.
REQ-007 diag_ram_address  out  16; diag_ram_datain  out  8; diag_ram_cs  out  1; diag_ram_we  out  1  RAM port; ram_dataout  in  8  RAM read data, valid 1 clk after cs.
REQ-008 configuration  in  4  active ROM config; out_flash_addr  in  4  flash image index.
REQ-009 vram_read_address  out  11; vram_output  in  8, valid 1 clk after address; vram_read_clock  out  1.
REQ-010 config_byte  out  4  selected VRAM window index.

Function
REQ-011 SHALL pass diag_spi_cs, spi_clk_in, spi_miso through 2-flop synchronizers; SPI mode 0, MSB first, 8-bit frames; bit sampled on synchronized SCK rising edge, diag_spi_out updated on falling edge.
REQ-012 SHALL return diag_spi_cs high mid-frame -> discard partial byte, state to IDLE; halt and config_byte retained.
REQ-013 First byte after cs falls = command; reply to byte N is shifted out during byte N+1; unknown command -> reply 0x00, ignore rest of transaction.
REQ-014 Commands: 0x01 HALT -> halt=1; 0x02 RUN -> halt=0; 0x03 READ_RAM(addrH,addrL) then stream; 0x04 WRITE_RAM(addrH,addrL) then data bytes; 0x05 READ_VRAM(addrH,addrL, low 11 bits used) then stream; 0x06 STATUS -> next reply {out_flash_addr,configuration}; 0x07 SET_CFG(byte) -> config_byte=byte[3:0]; 0x08 ECHO -> each byte echoed in next frame.
REQ-015 halt SHALL change on the clk following the 8th bit of the command byte.
REQ-016 READ_RAM: after addrL, and after each subsequent byte, SHALL pulse diag_ram_cs 1 clk with we=0, latch ram_dataout next clk as reply, increment address (16-bit wrap 0xFFFF->0x0000).
REQ-017 WRITE_RAM: per completed data byte SHALL drive datain, pulse cs and we together 1 clk, then increment address with wrap.
REQ-018 RAM commands while halt=0 SHALL not assert diag_ram_cs/we; replies 0x00.
REQ-019 diag_ram_cs/we 0 whenever no access pending; diag_ram_address holds last value.
REQ-020 READ_VRAM: same streaming as READ_RAM via vram_read_address, 11-bit wrap 0x7FF->0x000; allowed regardless of halt.
REQ-021 vram_read_clock SHALL equal clk.
REQ-022 Design SHALL assume clk >= 8x SCK; prefetch completes within 4 clk of byte end.

Reset
REQ-023 On reset low at clk edge: halt=0, config_byte=0, diag_ram_cs=0, diag_ram_we=0, diag_ram_address=0, diag_ram_datain=0, vram_read_address=0, diag_spi_out=0, shift state IDLE.
REQ-024 Reset mid-transaction SHALL abort it; the next transaction starts only after diag_spi_cs high then low.

Configuration
REQ-025 Macro DIAG_VRAM_READ_EN defined: READ_VRAM as REQ-020. Undefined: 0x05 treated as unknown command, vram_read_address tied 0, vram_read_clock tied 0.

Verification
REQ-026 Reset, then send 0x01 -> halt=1; send 0x02 -> halt=0; no RAM cs pulses.
REQ-027 Halted, WRITE_RAM 0x04,0x12,0x34,0xAA,0x55 -> we pulses at 0x1234=0xAA, 0x1235=0x55; READ_RAM 0x03,0x12,0x34,x,x,x -> replies 0xAA,0x55 in frames 4,5.
REQ-028 Halted, READ_RAM at 0xFFFF streaming 2 bytes -> addresses 0xFFFF then 0x0000.
REQ-029 configuration=0x5, out_flash_addr=0xA, STATUS 0x06,0x00 -> second reply 0xA5; SET_CFG 0x07,0x03 -> config_byte=3.
REQ-030 Not halted, WRITE_RAM 0x04,0x00,0x10,0x77 -> diag_ram_we never asserted; READ_VRAM 0x05,0x07,0xFF,x,x with macro -> addresses 0x7FF then 0x000.
REQ-031 cs raised after 4 bits of 0x01 -> halt unchanged; next full 0x08,0x3C,0x00 -> 0x3C echoed in frame 3.
